// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and its read-side companions.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  localparam int unsigned MAX_FIFO_W = 72;

  // Width of a source-id tag; a single source still carries a 1-bit tag.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational cyclic priority search: first set request at or after ptr, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic [IW:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; entries are tagged {src_id, last, data}.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned ID_W       = id_width(NUM_REQ),
  parameter int unsigned FIFO_W     = DATA_WIDTH + ID_W + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_last,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [FIFO_W-1:0]                    fifo_wdata,
  output logic                                 fifo_wen,
  input  logic                                 fifo_wready,
  input  logic                                 fifo_werr,
  output logic                                 busy,
  output logic [ID_W-1:0]                      cur_id,
  output logic                                 err
);

  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  if (FIFO_W > MAX_FIFO_W) begin : g_chk_fifo_w
    $error("fifo_write_arbiter: FIFO_W=%0d exceeds %0d", FIFO_W, MAX_FIFO_W);
  end
  if (FIFO_W != DATA_WIDTH + ID_W + 1) begin : g_chk_fifo_w_sum
    $error("fifo_write_arbiter: FIFO_W must equal DATA_WIDTH+ID_W+1");
  end
  if (NUM_REQ < 1 || MAX_BURST < 1) begin : g_chk_params
    $error("fifo_write_arbiter: NUM_REQ and MAX_BURST must be >= 1");
  end

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_grant_id;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_err;

  logic              w_found;
  logic [ID_W-1:0]   w_pick;
  logic              w_gvalid;
  logic              w_glast;
  logic [DATA_WIDTH-1:0] w_gdata;
  logic              w_burst_end;
  logic [ID_W-1:0]   w_rr_nxt;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .found (w_found),
    .idx   (w_pick)
  );

  assign w_gvalid = req_valid[r_grant_id];
  assign w_glast  = req_last[r_grant_id];
  assign w_gdata  = req_data[r_grant_id];
  assign w_rr_nxt = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

  // Handshake outputs are masked by rst so nothing is written on the reset cycle.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    fifo_wen    = 1'b0;
    w_burst_end = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_found) w_state_nxt = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        req_ready[r_grant_id] = fifo_wready & ~rst;
        fifo_wen              = w_gvalid & fifo_wready & ~rst;
        if (fifo_wen && (w_glast || r_beat_cnt == LAST_BEAT)) begin
          w_burst_end = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_IDLE && w_found) r_grant_id <= w_pick;
      if (w_burst_end) begin
        r_beat_cnt <= '0;
        r_rr_ptr   <= w_rr_nxt;
      end else if (fifo_wen) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
      if (fifo_werr || (fifo_wen && !fifo_wready)) r_err <= 1'b1;
    end
  end

  assign fifo_wdata = {r_grant_id, w_glast, w_gdata};
  assign busy       = (r_state == ARB_LOCKED);
  assign cur_id     = r_grant_id;
  assign err        = r_err;

endmodule
